sound_scheduler: RTL and testbench
==================================

Name: sound_scheduler

Overview:
- Sequences the audio generator from the six sound-request lines of the game (X keys, Y keys, Enter key, hole collision, border collision, ball-to-ball collision).
- Edge-detects each request and queues it as one pending bit per source.
- Arbitrates by fixed priority, with preemption by strictly higher priority, and plays one tone at a time for a per-sound duration followed by a silent gap.
- Sits between the request mux and the tone/frequency generator feeding the audio codec.

Parameters:
- TICK_CYCLES, 31500, clock cycles per 1 ms tick (31.5 MHz clock).
- HOLE_MS, 400, hole-collision tone length in ticks.
- BALL_MS, 80, ball-to-ball tone length in ticks.
- BORDER_MS, 60, border tone length in ticks.
- ENTER_MS, 150, Enter-key tone length in ticks.
- KEY_MS, 30, X/Y key tone length in ticks.
- GAP_MS, 10, silent gap after each tone in ticks (0 allowed).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- mute  in  1  level; while high, all requests are ignored and playback is forced silent
- keyXAudioRequest  in  1  level request, X-axis key
- keyYAudioRequest  in  1  level request, Y-axis key
- keyEnterAudioRequest  in  1  level request, Enter key
- holeColAudioRequest  in  1  level request, ball fell in hole
- borderColAudioRequest  in  1  level request, border hit
- ballToBallColAudioRequest  in  1  level request, ball-to-ball hit
- soundEnable  out  1  high while a tone plays
- toneIndex  out  3  tone code: 0 none, 1 hole, 2 ball, 3 border, 4 enter, 5 keyX, 6 keyY
- startPulse  out  1  one-cycle pulse on every tone start, including a preemption
- busy  out  1  high in PLAY or GAP

Behaviour:
- Reset (async, active-high):
  - State = IDLE.
  - Pending bits, previous-sample registers and counters all = 0.
  - soundEnable = 0, toneIndex = 0, startPulse = 0, busy = 0.
  - Reset asserted mid-tone aborts the tone immediately.
- Edge detect:
  - prev[i] is registered every cycle.
  - A rising edge is req[i] & ~prev[i].
  - A rising edge sets pending[i] at that clock edge. Held levels do not retrigger.
- Priority, highest first: hole, ball, border, enter, keyX, keyY.
- Pending bits are single-occurrence. Repeated edges while a bit is already set collapse into one.
- If a set and a clear of the same pending bit coincide, set wins.
- IDLE:
  - If any pending bit is set, grant the highest-priority one.
  - On grant: clear its pending bit, load the duration, go to PLAY.
  - toneIndex and soundEnable become valid the cycle after the grant decision.
  - startPulse is high for that same first PLAY cycle.
  - Latency: edge sampled at cycle n, pending set at n+1, soundEnable=1 at n+2.
- PLAY:
  - The tick prescaler restarts at every tone start.
  - The tone lasts exactly DUR*TICK_CYCLES cycles.
  - At expiry: soundEnable=0, toneIndex=0, go to GAP. If GAP_MS=0, go straight to IDLE.
- Preemption:
  - In PLAY, a pending source with strictly higher priority than the current tone replaces it the next cycle.
  - The new tone starts with a fresh startPulse and restarted counters.
  - The preempted tone is dropped, not requeued.
  - Equal or lower priority requests wait.
  - A new edge from the currently playing source sets pending and replays after the gap.
- GAP:
  - Lasts GAP_MS*TICK_CYCLES cycles with soundEnable=0 and busy=1.
  - Then IDLE; arbitration happens in IDLE.
- Mute:
  - While mute=1: pending bits are held at 0, edges are ignored, state is forced to IDLE, all outputs are 0.
  - prev[] still tracks inputs, so a level held across unmute does not trigger.
- Counters: the duration counter is sized to hold max(duration)*TICK_CYCLES and saturates at 0. There is no wrap-around.

Test Plan (bench overrides TICK_CYCLES=4, HOLE_MS=5, BALL_MS=3, BORDER_MS=2, ENTER_MS=2, KEY_MS=1, GAP_MS=1):
- Reset release, one-cycle keyX pulse at cycle 10 -> startPulse and toneIndex=5 at cycle 12; soundEnable high for cycles 12–15; busy through GAP to cycle 19; idle at 20.
- keyX held high for 100 cycles -> exactly one tone; no retrigger.
- border and keyY rise in the same cycle -> toneIndex=3 for 8 cycles, gap 4 cycles, then toneIndex=6 for 4 cycles.
- keyY playing, hole edge at the 2nd PLAY cycle -> toneIndex=1 two cycles later with a new startPulse, held 20 cycles; keyY not replayed.
- ball playing, three further ball edges -> after the gap, exactly one more ball tone (12 cycles).
- hole playing, mute raised -> next cycle all outputs 0, pending empty.
- Second case: hole playing, reset pulsed -> outputs 0 asynchronously.

Source files
------------

// File: rtl/sound_scheduler.sv
// Sound request scheduler: edge-detects six request lines, queues one pending bit
// per source and plays one tone at a time by fixed priority with preemption.
module sound_scheduler #(
  parameter int unsigned TICK_CYCLES = 31500,
  parameter int unsigned HOLE_MS     = 400,
  parameter int unsigned BALL_MS     = 80,
  parameter int unsigned BORDER_MS   = 60,
  parameter int unsigned ENTER_MS    = 150,
  parameter int unsigned KEY_MS      = 30,
  parameter int unsigned GAP_MS      = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mute,
  input  logic       keyXAudioRequest,
  input  logic       keyYAudioRequest,
  input  logic       keyEnterAudioRequest,
  input  logic       holeColAudioRequest,
  input  logic       borderColAudioRequest,
  input  logic       ballToBallColAudioRequest,
  output logic       soundEnable,
  output logic [2:0] toneIndex,
  output logic       startPulse,
  output logic       busy
);

  function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_MS  = maxU(maxU(maxU(HOLE_MS, BALL_MS), maxU(BORDER_MS, ENTER_MS)),
                                         maxU(KEY_MS, GAP_MS));
  localparam int unsigned MAX_CYC = MAX_MS * TICK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 2);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam cnt_t GAP_CYC = cnt_t'(GAP_MS * TICK_CYCLES);

  // Bit order matches priority: bit 0 = hole (highest) ... bit 5 = keyY.
  function automatic cnt_t durCycles(input logic [2:0] idx);
    case (idx)
      3'd0:    return cnt_t'(HOLE_MS * TICK_CYCLES);
      3'd1:    return cnt_t'(BALL_MS * TICK_CYCLES);
      3'd2:    return cnt_t'(BORDER_MS * TICK_CYCLES);
      3'd3:    return cnt_t'(ENTER_MS * TICK_CYCLES);
      default: return cnt_t'(KEY_MS * TICK_CYCLES);
    endcase
  endfunction

  state_t     state, stateNext;
  logic [5:0] req, prev, rise, pending, pendingNext;
  logic [2:0] cur, curNext, hitIdx, hitCode;
  cnt_t       cnt, cntNext;
  logic       startQ, grant, hit;

  assign req  = {keyYAudioRequest, keyXAudioRequest, keyEnterAudioRequest,
                 borderColAudioRequest, ballToBallColAudioRequest, holeColAudioRequest};
  assign rise = req & ~prev;

  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (pending[i] && !hit) begin
        hit    = 1'b1;
        hitIdx = 3'(i);
      end
    end
  end
  assign hitCode = hitIdx + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      prev    <= '0;
      pending <= '0;
      cur     <= '0;
      cnt     <= '0;
      startQ  <= 1'b0;
    end else begin
      state   <= stateNext;
      prev    <= req;
      pending <= pendingNext;
      cur     <= curNext;
      cnt     <= cntNext;
      startQ  <= grant;
    end
  end

  always_comb begin
    stateNext = state;
    curNext   = cur;
    cntNext   = cnt;
    grant     = 1'b0;
    unique case (state)
      IDLE: grant = hit;
      PLAY: begin
        if (hit && (hitCode < cur)) begin
          grant = 1'b1;
        end else if (cnt <= cnt_t'(1)) begin
          if (GAP_MS == 0) begin
            stateNext = IDLE;
          end else begin
            stateNext = GAP;
            cntNext   = GAP_CYC;
          end
        end else begin
          cntNext = cnt - cnt_t'(1);
        end
      end
      GAP: begin
        if (cnt <= cnt_t'(1)) stateNext = IDLE;
        else                  cntNext   = cnt - cnt_t'(1);
      end
      default: stateNext = IDLE;
    endcase
    if (grant) begin
      stateNext = PLAY;
      curNext   = hitCode;
      cntNext   = durCycles(hitIdx);
    end
    // Rise is OR-ed in after the grant clear so a coincident new edge is kept.
    pendingNext = (pending & ~(grant ? (6'b1 << hitIdx) : 6'b0)) | rise;
    if (mute) begin
      stateNext   = IDLE;
      grant       = 1'b0;
      pendingNext = '0;
      curNext     = '0;
      cntNext     = '0;
    end
  end

  always_comb begin
    soundEnable = (state == PLAY);
    toneIndex   = (state == PLAY) ? cur : 3'd0;
    startPulse  = startQ;
    busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_sound_scheduler.sv
// Self-checking bench for sound_scheduler: behavioural cycle model plus directed
// literal checks of the documented scenarios and a randomized soak.
module tb_sound_scheduler;
  localparam int TICK = 4;
  localparam int HOLE_MS = 5, BALL_MS = 3, BORDER_MS = 2, ENTER_MS = 2, KEY_MS = 1, GAP_MS = 1;

  logic clk = 1'b0, rst = 1'b1, mute = 1'b0;
  logic [5:0] req = '0;
  logic soundEnable, startPulse, busy;
  logic [2:0] toneIndex;

  int passCnt = 0, checkCnt = 0;
  int starts[7], onCyc[7];

  always #5 clk = ~clk;

  sound_scheduler #(
    .TICK_CYCLES(TICK), .HOLE_MS(HOLE_MS), .BALL_MS(BALL_MS), .BORDER_MS(BORDER_MS),
    .ENTER_MS(ENTER_MS), .KEY_MS(KEY_MS), .GAP_MS(GAP_MS)
  ) dut (
    .clk(clk), .reset(rst), .mute(mute),
    .keyXAudioRequest(req[4]), .keyYAudioRequest(req[5]), .keyEnterAudioRequest(req[3]),
    .holeColAudioRequest(req[0]), .borderColAudioRequest(req[2]),
    .ballToBallColAudioRequest(req[1]),
    .soundEnable(soundEnable), .toneIndex(toneIndex), .startPulse(startPulse), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checkCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: requests indexed by priority rank (0 = hole); tone code = rank + 1.
  function automatic int durMs(input int rank);
    case (rank)
      0: return HOLE_MS;
      1: return BALL_MS;
      2: return BORDER_MS;
      3: return ENTER_MS;
      default: return KEY_MS;
    endcase
  endfunction

  bit [5:0] mPrev, mPend, mRise;
  bit mPlay, mStart;
  int mLeft, mGap, mCur, mBest;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mPrev = '0; mPend = '0; mPlay = 0; mStart = 0; mLeft = 0; mGap = 0; mCur = 0;
    end else begin
      mRise = req & ~mPrev;
      mPrev = req;
      if (mute) begin
        mPend = '0; mPlay = 0; mStart = 0; mGap = 0; mCur = 0;
      end else begin
        mBest = -1;
        for (int i = 0; i < 6; i++) if (mPend[i] && mBest < 0) mBest = i;
        mStart = 0;
        if (mBest >= 0 && ((!mPlay && mGap == 0) || (mPlay && mBest + 1 < mCur))) begin
          mPend[mBest] = 0;
          mCur = mBest + 1;
          mLeft = durMs(mBest) * TICK;
          mPlay = 1;
          mStart = 1;
        end else if (mPlay) begin
          if (mLeft <= 1) begin mPlay = 0; mGap = GAP_MS * TICK; end
          else mLeft--;
        end else if (mGap > 0) begin
          mGap--;
        end
        mPend |= mRise;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("soundEnable", int'(soundEnable), int'(mPlay));
      chk("toneIndex", int'(toneIndex), mPlay ? mCur : 0);
      chk("startPulse", int'(startPulse), int'(mStart));
      chk("busy", int'(busy), int'(mPlay || mGap > 0));
      if (startPulse) starts[toneIndex]++;
      if (soundEnable) onCyc[toneIndex]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int idx);
    req[idx] = 1'b1;
    tick();
    req[idx] = 1'b0;
  endtask

  task automatic clearStats();
    for (int i = 0; i < 7; i++) begin starts[i] = 0; onCyc[i] = 0; end
  endtask

  int eSE[10]  = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int eTI[10]  = '{0, 5, 5, 5, 5, 0, 0, 0, 0, 0};
  int eSP[10]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int eBSY[10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    clearStats();
    #2;
    chk("rst_se", int'(soundEnable), 0);
    chk("rst_ti", int'(toneIndex), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sp", int'(startPulse), 0);
    #20 rst = 1'b0;
    repeat (6) tick();

    // Single keyX pulse: tone two edges after sampling, 4 cycles, 4-cycle gap.
    pulse(4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("litX_se", int'(soundEnable), eSE[k]);
      chk("litX_ti", int'(toneIndex), eTI[k]);
      chk("litX_sp", int'(startPulse), eSP[k]);
      chk("litX_busy", int'(busy), eBSY[k]);
    end
    repeat (5) tick();

    clearStats();
    req[4] = 1'b1;
    repeat (100) tick();
    req[4] = 1'b0;
    repeat (10) tick();
    chk("heldX_starts", starts[5], 1);

    clearStats();
    req[2] = 1'b1; req[5] = 1'b1;
    tick();
    req = '0;
    repeat (30) tick();
    chk("bord_cyc", onCyc[3], 8);
    chk("keyY_cyc", onCyc[6], 4);
    chk("keyY_starts", starts[6], 1);

    clearStats();
    pulse(5);
    repeat (2) tick();
    pulse(0);
    repeat (40) tick();
    chk("pre_hole_cyc", onCyc[1], 20);
    chk("pre_hole_starts", starts[1], 1);
    chk("pre_keyY_starts", starts[6], 1);

    clearStats();
    pulse(1);
    tick(); tick();
    pulse(1); tick();
    pulse(1); tick();
    pulse(1);
    repeat (40) tick();
    chk("ball_starts", starts[2], 2);
    chk("ball_cyc", onCyc[2], 24);

    pulse(0);
    repeat (4) tick();
    mute = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mute_se", int'(soundEnable), 0);
    chk("mute_ti", int'(toneIndex), 0);
    chk("mute_busy", int'(busy), 0);
    chk("mute_sp", int'(startPulse), 0);
    #1;
    clearStats();
    req[0] = 1'b1;
    repeat (3) tick();
    mute = 1'b0;
    repeat (10) tick();
    req[0] = 1'b0;
    repeat (5) tick();
    chk("unmute_starts", starts[1], 0);

    pulse(0);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_se", int'(soundEnable), 0);
    chk("arst_ti", int'(toneIndex), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_sp", int'(startPulse), 0);
    #10 rst = 1'b0;
    repeat (3) tick();

    repeat (4000) begin
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 39) == 0) req[i] = ~req[i];
      if (!mute && $urandom_range(0, 499) == 0) mute = 1'b1;
      else if (mute && $urandom_range(0, 29) == 0) mute = 1'b0;
      tick();
    end
    mute = 1'b0;
    req = '0;
    repeat (40) tick();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
